// File: rtl/bitrev_spi_master_if.sv
// Request/response handshake plus SPI pins for the bit-reverse SPI master.
// The core side uses the master modport; the SPI engine uses the slave modport.
interface bitrev_spi_master_if;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_data;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] resp_data;
   logic       busy;
   logic       spi_sck;
   logic       spi_ss;
   logic       spi_mosi;
   logic       spi_miso;

   modport master (
      output req_valid, req_data, resp_ready,
      input  req_ready, resp_valid, resp_data, busy
   );

   modport slave (
      input  req_valid, req_data, resp_ready, spi_miso,
      output req_ready, resp_valid, resp_data, busy, spi_sck, spi_ss, spi_mosi
   );
endinterface

// File: rtl/bitrev_spi_master.sv
// Mode-0, MSB-first SPI master running one 16-clock exchange with the bit-reverse slave:
// 8 clocks shift the request out, the next 8 clocks bring the reversed byte back.
module bitrev_spi_master #(
   parameter int unsigned DIV_HALF = 2,
   parameter int unsigned SS_SETUP = 2,
   parameter int unsigned SS_HOLD  = 2,
   parameter int unsigned SS_GAP   = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   bitrev_spi_master_if.slave     io_bus
);

   localparam int unsigned MaxSs0 = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
   localparam int unsigned MaxSs  = (MaxSs0 > SS_GAP) ? MaxSs0 : SS_GAP;
   localparam int unsigned CntW   = (MaxSs > 1) ? $clog2(MaxSs) : 1;
   localparam int unsigned HalfW  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

   localparam logic [CntW-1:0]  SetupLast = CntW'(SS_SETUP - 1);
   localparam logic [CntW-1:0]  HoldLast  = CntW'(SS_HOLD - 1);
   localparam logic [CntW-1:0]  GapLast   = CntW'(SS_GAP - 1);
   localparam logic [HalfW-1:0] HalfLast  = HalfW'(DIV_HALF - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StDone,
      StGap
   } state_e;

   state_e           r_state, w_state_d;
   logic [CntW-1:0]  r_cnt, w_cnt_d;
   logic [HalfW-1:0] r_half, w_half_d;
   logic [4:0]       r_edge, w_edge_d;
   logic             r_sck, w_sck_d;
   logic [7:0]       r_tx_sh, w_tx_sh_d;
   logic [7:0]       r_rx_sh, w_rx_sh_d;
   logic [7:0]       r_resp_data, w_resp_data_d;

   logic             w_req_ready;
   logic             w_resp_valid;
   logic             w_busy;
   logic             w_ss;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_half      <= '0;
         r_edge      <= '0;
         r_sck       <= 1'b0;
         r_tx_sh     <= '0;
         r_rx_sh     <= '0;
         r_resp_data <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_half      <= w_half_d;
         r_edge      <= w_edge_d;
         r_sck       <= w_sck_d;
         r_tx_sh     <= w_tx_sh_d;
         r_rx_sh     <= w_rx_sh_d;
         r_resp_data <= w_resp_data_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_half_d      = r_half;
      w_edge_d      = r_edge;
      w_sck_d       = r_sck;
      w_tx_sh_d     = r_tx_sh;
      w_rx_sh_d     = r_rx_sh;
      w_resp_data_d = r_resp_data;
      w_req_ready   = 1'b0;
      w_resp_valid  = 1'b0;
      w_busy        = 1'b1;
      w_ss          = 1'b1;

      unique case (r_state)
         StIdle: begin
            w_req_ready = 1'b1;
            w_busy      = 1'b0;
            if (io_bus.req_valid) begin
               w_tx_sh_d = io_bus.req_data;
               w_cnt_d   = '0;
               w_state_d = StSetup;
            end
         end
         StSetup: begin
            w_ss = 1'b0;
            if (r_cnt == SetupLast) begin
               // First rising edge is issued on the way into SHIFT.
               w_cnt_d   = '0;
               w_half_d  = '0;
               w_edge_d  = 5'd1;
               w_sck_d   = 1'b1;
               w_state_d = StShift;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         StShift: begin
            w_ss = 1'b0;
            if (r_half == HalfLast) begin
               w_half_d = '0;
               if (r_sck) begin
                  w_sck_d   = 1'b0;
                  w_tx_sh_d = {r_tx_sh[6:0], 1'b0};
                  // Slave returns its bits during rises 8..15.
                  if (r_edge >= 5'd8 && r_edge <= 5'd15) begin
                     w_rx_sh_d = {r_rx_sh[6:0], io_bus.spi_miso};
                  end
               end else if (r_edge == 5'd16) begin
                  w_cnt_d   = '0;
                  w_state_d = StHold;
               end else begin
                  w_sck_d  = 1'b1;
                  w_edge_d = r_edge + 5'd1;
               end
            end else begin
               w_half_d = r_half + 1'b1;
            end
         end
         StHold: begin
            w_ss = 1'b0;
            if (r_cnt == HoldLast) begin
               w_cnt_d       = '0;
               w_resp_data_d = r_rx_sh;
               w_state_d     = StDone;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         StDone: begin
            w_resp_valid = 1'b1;
            if (io_bus.resp_ready) begin
               w_cnt_d   = '0;
               w_state_d = StGap;
            end
         end
         StGap: begin
            if (r_cnt == GapLast) begin
               w_cnt_d   = '0;
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign io_bus.req_ready  = w_req_ready;
   assign io_bus.resp_valid = w_resp_valid;
   assign io_bus.resp_data  = r_resp_data;
   assign io_bus.busy       = w_busy;
   assign io_bus.spi_sck    = r_sck;
   assign io_bus.spi_ss     = w_ss;
   assign io_bus.spi_mosi   = r_tx_sh[7];

endmodule

// File: tb/tb_bitrev_spi_master.sv
// Bench for bitrev_spi_master: three builds (DIV_HALF 2, 1, 5), each wired to a behavioural
// bit-reverse slave, with a queue of expected responses filled as requests are issued.
module tb_bitrev_spi_master;

   localparam int unsigned SsSetup = 2;
   localparam int unsigned SsHold  = 2;
   localparam int unsigned SsGap   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]       req_valid  = '0;
   logic [2:0]       resp_ready = '0;
   logic [2:0][7:0]  req_data   = '0;
   logic [2:0]       req_ready_w, resp_valid_w, busy_w, sck_w, ss_w, mosi_w;
   logic [2:0][7:0]  resp_data_w, rises_w, slv_cnt_w;
   logic [2:0][15:0] per_err_w, proto_err_w;

   int         checks   = 0;
   int         failures = 0;
   int         req_cyc  = 0;
   logic [7:0] exp_q[$];

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int unsigned Dh = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      logic [7:0] slv_sh     = '0;
      int         slv_cnt    = 0;
      int         last_rises = 0;
      logic       prev_sck   = 1'b0;
      logic       prev_ss    = 1'b1;
      logic       prev_rst   = 1'b0;
      logic       rise_seen  = 1'b0;
      int         last_rise  = 0;
      int         per_err    = 0;
      int         proto_err  = 0;

      bitrev_spi_master_if u_bus ();

      assign u_bus.req_valid  = req_valid[g];
      assign u_bus.req_data   = req_data[g];
      assign u_bus.resp_ready = resp_ready[g];
      assign u_bus.spi_miso   = slv_sh[0];

      assign req_ready_w[g]  = u_bus.req_ready;
      assign resp_valid_w[g] = u_bus.resp_valid;
      assign resp_data_w[g]  = u_bus.resp_data;
      assign busy_w[g]       = u_bus.busy;
      assign sck_w[g]        = u_bus.spi_sck;
      assign ss_w[g]         = u_bus.spi_ss;
      assign mosi_w[g]       = u_bus.spi_mosi;
      assign rises_w[g]      = 8'(last_rises);
      assign slv_cnt_w[g]    = 8'(slv_cnt);
      assign per_err_w[g]    = 16'(per_err);
      assign proto_err_w[g]  = 16'(proto_err);

      bitrev_spi_master #(
         .DIV_HALF (Dh),
         .SS_SETUP (SsSetup),
         .SS_HOLD  (SsHold),
         .SS_GAP   (SsGap)
      ) u_dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .io_bus  (u_bus)
      );

      // Slave: shifts in 8 bits MSB first, then shifts them back out LSB first.
      always @(posedge u_bus.spi_sck or posedge u_bus.spi_ss) begin
         if (u_bus.spi_ss) begin
            last_rises <= slv_cnt;
            slv_cnt    <= 0;
         end else begin
            slv_cnt <= slv_cnt + 1;
            if (slv_cnt < 8) slv_sh <= {slv_sh[6:0], u_bus.spi_mosi};
            else             slv_sh <= {1'b0, slv_sh[7:1]};
         end
      end

      always @(negedge clk) begin
         prev_sck <= u_bus.spi_sck;
         prev_ss  <= u_bus.spi_ss;
         prev_rst <= rst_n;
         if (rst_n && prev_rst) begin
            if (u_bus.spi_sck && !prev_sck) begin
               if (rise_seen && (cyc - last_rise) != int'(2 * Dh)) per_err <= per_err + 1;
               last_rise <= cyc;
               rise_seen <= 1'b1;
            end else if (u_bus.spi_ss) begin
               rise_seen <= 1'b0;
            end
            if ((prev_ss && (u_bus.spi_sck != prev_sck)) ||
                (prev_sck && (u_bus.spi_ss != prev_ss))) begin
               proto_err <= proto_err + 1;
            end
         end
      end
   end

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   function automatic int dh_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int g, input logic [7:0] d);
      int n = 0;
      while (req_ready_w[g] !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_send", 32'(req_ready_w[g]), 32'd1);
      req_valid[g] = 1'b1;
      req_data[g]  = d;
      req_cyc      = cyc;
      exp_q.push_back(rev8(d));
      @(negedge clk);
      req_valid[g] = 1'b0;
      chk("busy_after_accept", 32'(busy_w[g]), 32'd1);
   endtask

   task automatic recv(input int g, input int stall);
      int         n   = 0;
      int         bad = 0;
      logic [7:0] exp = '0;
      logic [7:0] held;
      resp_ready[g] = 1'b0;
      while (resp_valid_w[g] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("resp_valid_seen", 32'(resp_valid_w[g]), 32'd1);
      chk("latency", 32'(cyc - req_cyc), 32'(SsSetup + 32 * dh_of(g) + SsHold + 1));
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      chk("resp_data", 32'(resp_data_w[g]), 32'(exp));
      chk("sck_rises", 32'(rises_w[g]), 32'd16);
      chk("ss_high_in_done", 32'(ss_w[g]), 32'd1);
      held = resp_data_w[g];
      if (stall > 0) begin
         repeat (stall) begin
            @(negedge clk);
            if (resp_valid_w[g] !== 1'b1 || resp_data_w[g] !== held || req_ready_w[g] !== 1'b0 ||
                ss_w[g] !== 1'b1 || sck_w[g] !== 1'b0) bad++;
         end
         chk("stall_hold", 32'(bad), 32'd0);
      end
      resp_ready[g] = 1'b1;
      @(negedge clk);
      resp_ready[g] = 1'b0;
      chk("resp_valid_clear", 32'(resp_valid_w[g]), 32'd0);
      n   = 0;
      bad = 0;
      while (req_ready_w[g] !== 1'b1 && n < 100) begin
         if (ss_w[g] !== 1'b1) bad++;
         @(negedge clk);
         n++;
      end
      chk("gap_cycles", 32'(n), 32'(SsGap));
      chk("gap_ss_high", 32'(bad), 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      repeat (3) @(negedge clk);
      chk("rst_ss", 32'(ss_w[0]), 32'd1);
      chk("rst_sck", 32'(sck_w[0]), 32'd0);
      chk("rst_mosi", 32'(mosi_w[0]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid_w[0]), 32'd0);
      chk("rst_resp_data", 32'(resp_data_w[0]), 32'd0);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_req_ready", 32'(req_ready_w[0]), 32'd1);
      rst_n = 1'b1;

      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ss_w !== 3'b111 || sck_w !== 3'b000 || mosi_w !== 3'b000 ||
             req_ready_w !== 3'b111 || resp_valid_w !== 3'b000) bad++;
      end
      chk("idle_20", 32'(bad), 32'd0);

      send(0, 8'h01);
      recv(0, 0);

      send(0, 8'hA5);
      recv(0, 0);
      send(0, 8'h12);
      recv(0, 0);
      send(0, 8'hF0);
      recv(0, 0);

      send(0, 8'h5A);
      recv(0, 50);

      // Abort a transaction right after the fifth sck rise.
      send(0, 8'hC3);
      n = 0;
      while (slv_cnt_w[0] != 8'd5 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rise5_sck_high", 32'(sck_w[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_ss", 32'(ss_w[0]), 32'd1);
      chk("abort_sck", 32'(sck_w[0]), 32'd0);
      chk("abort_busy", 32'(busy_w[0]), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, 8'h3C);
      recv(0, 0);

      send(1, 8'h81);
      recv(1, 0);
      send(2, 8'h81);
      recv(2, 0);

      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk("sck_period", 32'(per_err_w[g]), 32'd0);
         chk("ss_sck_protocol", 32'(proto_err_w[g]), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
